// File: rtl/seg_pkg.sv
// Shared constants and helpers for the probe display: hex-to-segment table,
// the blank segment pattern and a one-hot test.
package seg_pkg;

    localparam int REFRESH_DIV_DEFAULT = 100000;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} patterns for nibble values 0..F
    localparam logic [6:0] HEX7 [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Vectors up to 64 bits wide; callers zero-extend narrower selects
    function automatic logic is_onehot(input logic [63:0] v);
        int unsigned n;
        n = 32'd0;
        for (int i = 0; i < 64; i++) begin
            n = n + 32'(v[i]);
        end
        return (n == 32'd1);
    endfunction

endpackage

// File: rtl/seg_hex7_decoder.sv
// Combinational nibble to active-low 7-segment pattern.
module seg_hex7_decoder
    import seg_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    // Table lookup of the segment pattern
    always_comb begin
        seg_o = HEX7[nib_i];
    end

endmodule

// File: rtl/seg_probe_display.sv
// Debug probe display: one-hot channel select, per-frame snapshot, paged hex
// scan on common-anode digits. Define SEG_BLANK_LEADING_ZERO_EN to blank leading zeros.
module seg_probe_display
    import seg_pkg::*;
#(
    parameter int N_CH        = 15,
    parameter int DATA_W      = 32,
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = REFRESH_DIV_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_CH*DATA_W-1:0]   probe_bus,
    input  logic [N_CH-1:0]          sel,
    input  logic                     freeze,
    input  logic                     page_next,
    output logic [6:0]               seg,
    output logic                     dp,
    output logic [DIGITS-1:0]        an,
    output logic                     sel_err
);

    localparam int PAGE_W = 4 * DIGITS;
    localparam int PAGES  = DATA_W / PAGE_W;
    localparam int CNT_W  = $clog2(REFRESH_DIV);
    localparam int DIG_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PG_W   = (PAGES > 1) ? $clog2(PAGES) : 1;

    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic [DIG_W-1:0]  dig_q,    dig_d;
    logic [PG_W-1:0]   page_q,   page_d;
    logic [DATA_W-1:0] shadow_q, shadow_d;
    logic [6:0]        seg_q,    seg_d;
    logic              dp_q,     dp_d;
    logic [DIGITS-1:0] an_q,     an_d;
    logic              sel_err_q, sel_err_d;

    logic [DATA_W-1:0] sel_word_s;
    logic              cnt_last_s;
    logic              frame_end_s;
    logic [31:0]       page_base_s;
    logic [31:0]       nib_idx_s;
    logic [3:0]        nib_s;
    logic [6:0]        hex_seg_s;
    logic              blank_s;

    assign cnt_last_s  = (cnt_q == CNT_W'(REFRESH_DIV - 1));
    assign frame_end_s = cnt_last_s && (dig_q == DIG_W'(DIGITS - 1));

    // Channel mux; anything but exactly one switch up reads as zero
    always_comb begin
        sel_word_s = '0;
        if (is_onehot(64'(sel))) begin
            for (int k = 0; k < N_CH; k++) begin
                if (sel[k]) begin
                    sel_word_s = probe_bus[k*DATA_W +: DATA_W];
                end else begin
                    sel_word_s = sel_word_s;
                end
            end
        end else begin
            sel_word_s = '0;
        end
    end

    // Refresh counter, digit scan, page stepping and frame snapshot
    always_comb begin
        cnt_d    = cnt_q;
        dig_d    = dig_q;
        page_d   = page_q;
        shadow_d = shadow_q;
        if (cnt_last_s) begin
            cnt_d = '0;
            dig_d = (dig_q == DIG_W'(DIGITS - 1)) ? '0 : dig_q + DIG_W'(1);
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (frame_end_s && !freeze) begin
            shadow_d = sel_word_s;
        end else begin
            shadow_d = shadow_q;
        end
        if (page_next) begin
            page_d = (page_q == PG_W'(PAGES - 1)) ? '0 : page_q + PG_W'(1);
        end else begin
            page_d = page_q;
        end
    end

    assign page_base_s = 32'(page_q) * 32'(PAGE_W);
    assign nib_idx_s   = page_base_s + 32'(dig_q) * 32'd4;
    assign nib_s       = 4'(shadow_q >> nib_idx_s);

    seg_hex7_decoder u_hex7 (
        .nib_i (nib_s),
        .seg_o (hex_seg_s)
    );

`ifdef SEG_BLANK_LEADING_ZERO_EN
    logic [PAGE_W-1:0] page_word_s;
    logic [PAGE_W-1:0] upper_s;

    // Digit is a leading zero when it and every nibble above it in the page are zero
    always_comb begin
        page_word_s = PAGE_W'(shadow_q >> page_base_s);
        upper_s     = page_word_s >> (32'(dig_q) * 32'd4);
        blank_s     = (dig_q != '0) && (upper_s == '0);
    end
`else
    assign blank_s = 1'b0;
`endif

    // Next values of the registered display outputs
    always_comb begin
        an_d      = ~(DIGITS'(1'b1) << dig_q);
        seg_d     = blank_s ? SEG_BLANK : hex_seg_s;
        dp_d      = (32'(dig_q) == (32'(page_q) % 32'(DIGITS))) ? 1'b0 : 1'b1;
        sel_err_d = ~is_onehot(64'(sel));
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            dig_q     <= '0;
            page_q    <= '0;
            shadow_q  <= '0;
            seg_q     <= SEG_BLANK;
            dp_q      <= 1'b1;
            an_q      <= '1;
            sel_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            dig_q     <= dig_d;
            page_q    <= page_d;
            shadow_q  <= shadow_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            an_q      <= an_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign seg     = seg_q;
    assign dp      = dp_q;
    assign an      = an_q;
    assign sel_err = sel_err_q;

endmodule

// File: tb/tb_seg_probe_display.sv
// Self-checking bench for seg_probe_display: directed pins plus a randomized run
// compared every cycle against a time-based display model.
module tb_seg_probe_display;

    localparam int N_CH   = 15;
    localparam int DATA_W = 32;
    localparam int DIGITS = 4;
    localparam int DIV    = 4;
    localparam int PAGES  = DATA_W / (4 * DIGITS);

    logic                   clk;
    logic                   reset;
    logic [N_CH*DATA_W-1:0] probe_bus;
    logic [N_CH-1:0]        sel;
    logic                   freeze;
    logic                   page_next;
    logic [6:0]             seg;
    logic                   dp;
    logic [DIGITS-1:0]      an;
    logic                   sel_err;

    int checks = 0;
    int passes = 0;

    seg_probe_display #(
        .N_CH(N_CH), .DATA_W(DATA_W), .DIGITS(DIGITS), .REFRESH_DIV(DIV)
    ) dut (
        .clk(clk), .reset(reset), .probe_bus(probe_bus), .sel(sel),
        .freeze(freeze), .page_next(page_next),
        .seg(seg), .dp(dp), .an(an), .sel_err(sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] hex_of(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Model: elapsed cycles since reset decide which digit is lit and when frames end
    int          t;
    int          mpage;
    logic [31:0] mshadow;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_dp;
    logic        exp_err;
    bit          mvalid = 1'b0;

    always @(posedge clk) begin : model
        int d;
        logic [31:0] word;
        logic [15:0] pw;
        logic [3:0]  nib;
        if (reset) begin
            t = 0; mpage = 0; mshadow = 32'h0;
            exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_err = 1'b0;
            mvalid = 1'b1;
        end else if (mvalid) begin
            d   = (t / DIV) % DIGITS;
            pw  = 16'(mshadow >> (mpage * 16));
            nib = 4'(pw >> (4 * d));
            exp_an  = ~(4'b0001 << d);
            exp_seg = hex_of(nib);
`ifdef SEG_BLANK_LEADING_ZERO_EN
            if (d > 0 && (pw >> (4 * d)) == 16'h0) exp_seg = 7'h7F;
`endif
            exp_dp  = (d == mpage % DIGITS) ? 1'b0 : 1'b1;
            exp_err = ($countones(sel) != 1);
            if ((t % (DIV * DIGITS)) == DIV * DIGITS - 1 && !freeze) begin
                word = 32'h0;
                if ($countones(sel) == 1)
                    for (int k = 0; k < N_CH; k++)
                        if (sel[k]) word = probe_bus[k*DATA_W +: DATA_W];
                mshadow = word;
            end
            if (page_next) mpage = (mpage + 1) % PAGES;
            t++;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (mvalid) begin
            chk("an",      32'(an),      32'(exp_an));
            chk("seg",     32'(seg),     32'(exp_seg));
            chk("dp",      32'(dp),      32'(exp_dp));
            chk("sel_err", 32'(sel_err), 32'(exp_err));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; probe_bus = '0; sel = '0; freeze = 1'b0; page_next = 1'b0;
        step(2);
        chk("rst_an",  32'(an),      32'hF);
        chk("rst_seg", 32'(seg),     32'h7F);
        chk("rst_dp",  32'(dp),      32'h1);
        chk("rst_err", 32'(sel_err), 32'h0);

        reset = 1'b0;
        probe_bus[31:0] = 32'h1234ABCD;
        sel = 15'h0001;
        step(1);
        chk("first_an",  32'(an),  32'hE);
        chk("first_seg", 32'(seg), 32'h40);
        step(16);
        chk("p0d0_an",  32'(an),  32'hE);
        chk("p0d0_seg", 32'(seg), 32'h21);
        chk("p0d0_dp",  32'(dp),  32'h0);
        step(4);
        chk("p0d1_an",  32'(an),  32'hD);
        chk("p0d1_seg", 32'(seg), 32'h46);
        chk("p0d1_dp",  32'(dp),  32'h1);
        step(4);
        chk("p0d2_seg", 32'(seg), 32'h03);
        step(4);
        chk("p0d3_an",  32'(an),  32'h7);
        chk("p0d3_seg", 32'(seg), 32'h08);
        page_next = 1'b1;
        step(1);
        page_next = 1'b0;
        step(3);
        chk("p1d0_seg", 32'(seg), 32'h19);
        chk("p1d0_dp",  32'(dp),  32'h1);
        step(4);
        chk("p1d1_seg", 32'(seg), 32'h30);
        chk("p1d1_dp",  32'(dp),  32'h0);

        // Randomized run with freezes, bad selects, page pulses and mid-frame resets
        for (int c = 0; c < 4000; c++) begin
            page_next = ($urandom_range(0, 19) == 0);
            reset     = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 49) == 0) freeze = ~freeze;
            if ($urandom_range(0, 39) == 0) begin
                if ($urandom_range(0, 3) == 0) sel = 15'($urandom);
                else sel = 15'(1) << $urandom_range(0, N_CH - 1);
            end
            if ($urandom_range(0, 9) == 0) begin
                int ch;
                ch = $urandom_range(0, N_CH - 1);
                case ($urandom_range(0, 2))
                    0: probe_bus[ch*DATA_W +: DATA_W] = $urandom & 32'h0000_00FF;
                    1: probe_bus[ch*DATA_W +: DATA_W] = $urandom & 32'h00F0_0F00;
                    default: probe_bus[ch*DATA_W +: DATA_W] = $urandom;
                endcase
            end
            step(1);
        end
        reset = 1'b0;
        page_next = 1'b0;
        step(2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
